// File: rtl/delay_line_freq_meter_pkg.sv
// Shared definitions for the delay-line frequency meter: FSM encoding, default code width
// and the timer width helper.
package delay_line_freq_meter_pkg;

    localparam int N_DEFAULT = 18;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GATE   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Timer only ever holds values up to max(settle, gate) - 1; keep at least one bit.
    function automatic int timer_width(input int settle_cycles, input int gate_cycles);
        int m;
        m = (settle_cycles > gate_cycles) ? settle_cycles : gate_cycles;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/delay_line_freq_meter_osc_edge_sync.sv
// Brings the looped-back oscillator into the CLOCK_50 domain and flags its rising edges.
// Two synchronizer flops followed by a history flop; pulse is one cycle wide.
module osc_edge_sync (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic async_in,
    output logic rise_pulse
);

    logic sync0_q, sync0_d;
    logic sync1_q, sync1_d;
    logic hist_q,  hist_d;

    always_comb begin
        sync0_d = async_in;
        sync1_d = sync0_q;
        hist_d  = sync1_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync0_q <= sync0_d;
            sync1_q <= sync1_d;
            hist_q  <= hist_d;
        end
    end

    assign rise_pulse = sync1_q & ~hist_q;

endmodule

// File: rtl/delay_line_freq_meter.sv
// Drives a delay code into the ring oscillator, waits SETTLE_CYCLES, then counts oscillator
// rising edges over GATE_CYCLES and presents the count with a valid/ready handshake.
module delay_line_freq_meter
    import delay_line_freq_meter_pkg::*;
#(
    parameter int N             = N_DEFAULT,
    parameter int CNT_W         = 32,
    parameter int SETTLE_CYCLES = 1024,
    parameter int GATE_CYCLES   = 50000
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [N-1:0]     CODE_IN,
    output logic [N-1:0]     CODE_OUT,
    input  logic             OSC_IN,
    output logic             BUSY,
    output logic [CNT_W-1:0] RESULT,
    output logic             RESULT_VALID,
    input  logic             RESULT_READY,
    output logic             OVERFLOW
);

    localparam int TW = timer_width(SETTLE_CYCLES, GATE_CYCLES);
    localparam logic [TW-1:0]    SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0]    GATE_LOAD   = TW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [N-1:0]     code_q, code_d;
    logic [CNT_W-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             rise;
    logic [CNT_W-1:0] count_next;

    osc_edge_sync u_sync (
        .CLOCK_50   (CLOCK_50),
        .RESET_N    (RESET_N),
        .async_in   (OSC_IN),
        .rise_pulse (rise)
    );

    // Saturating increment; includes the edge of the current cycle.
    assign count_next = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(rise);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        count_d  = count_q;
        code_d   = code_q;
        result_d = result_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    code_d  = CODE_IN;
                    timer_d = SETTLE_LOAD;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (timer_q == '0) begin
                    count_d = '0;
                    timer_d = GATE_LOAD;
                    state_d = GATE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            GATE: begin
                count_d = count_next;
                if (timer_q == '0) begin
                    result_d = count_next;
                    ovf_d    = (count_next == CNT_MAX);
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            DONE: begin
                // START in the handshake cycle is deliberately dropped.
                if (valid_q && RESULT_READY) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            count_q  <= '0;
            code_q   <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            count_q  <= count_d;
            code_q   <= code_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign CODE_OUT     = code_q;
    assign RESULT       = result_q;
    assign RESULT_VALID = valid_q;
    assign OVERFLOW     = ovf_q;
    assign BUSY         = (state_q != IDLE);

endmodule
